// File: rtl/instr_serial_loader.sv
// Serial-to-parallel instruction loader: assembles LSB-first 9-bit words from pins,
// buffers them in a small FIFO and issues them to the core with a one-cycle strobe.
module instr_serial_loader #(
  parameter int unsigned WORD_W = 9,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         SDATA,
  input  logic                         SVALID,
  input  logic                         SYNC,
  input  logic                         STALL,
  input  logic                         CLR_OVF,
  output logic [WORD_W-1:0]            INSTRUCTION,
  output logic                         WRITE_EN,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                         OVERFLOW
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  // Bit 0 of the assembly register is shifted out before it is ever used, so only
  // the upper WORD_W-1 bits are stored.
  logic [WORD_W-1:1] asm_q;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              bit_take_c;
  logic              word_done_c;
  logic [WORD_W-1:0] done_word_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [LVL_W-1:0]  level_next_c;

  always_comb begin
    bit_take_c   = SVALID && !SYNC;
    word_done_c  = bit_take_c && (bitcnt_q == CNT_W'(WORD_W - 1));
    done_word_c  = {SDATA, asm_q};
    pop_c        = !EMPTY && !STALL;
    push_c       = word_done_c && (!FULL || pop_c);
    drop_c       = word_done_c && FULL && !pop_c;
    level_next_c = LEVEL;
    if (push_c && !pop_c)      level_next_c = LEVEL + LVL_W'(1);
    else if (pop_c && !push_c) level_next_c = LEVEL - LVL_W'(1);
  end

  // Deserialiser; SYNC takes priority over a coincident bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      asm_q    <= '0;
      bitcnt_q <= '0;
    end else if (SYNC) begin
      bitcnt_q <= '0;
    end else if (SVALID) begin
      asm_q    <= {SDATA, asm_q[WORD_W-1:2]};
      bitcnt_q <= (bitcnt_q == CNT_W'(WORD_W - 1)) ? '0 : bitcnt_q + CNT_W'(1);
    end
  end

  // FIFO storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= done_word_c;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      LEVEL       <= '0;
      FULL        <= 1'b0;
      EMPTY       <= 1'b1;
      INSTRUCTION <= '0;
      WRITE_EN    <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        INSTRUCTION <= mem_q[rd_ptr_q];
      end
      WRITE_EN <= pop_c;
      LEVEL    <= level_next_c;
      FULL     <= (level_next_c == LVL_W'(DEPTH));
      EMPTY    <= (level_next_c == '0);
      if (drop_c)       OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_serial_loader.sv
// Directed bench for instr_serial_loader: expected issues are queued as words are
// sent and popped by a strobe monitor; state checks are made between steps.
module tb_instr_serial_loader;

  localparam int unsigned WORD_W = 9;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              SDATA, SVALID, SYNC, STALL, CLR_OVF;
  logic [WORD_W-1:0] INSTRUCTION;
  logic              WRITE_EN, FULL, EMPTY, OVERFLOW;
  logic [LVL_W-1:0]  LEVEL;

  int                vectors     = 0;
  int                miscompares = 0;
  int                strobes     = 0;
  logic [WORD_W-1:0] exp_q [$];

  instr_serial_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SDATA(SDATA), .SVALID(SVALID), .SYNC(SYNC),
    .STALL(STALL), .CLR_OVF(CLR_OVF), .INSTRUCTION(INSTRUCTION), .WRITE_EN(WRITE_EN),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected word.
  always @(posedge CLK) begin
    #1;
    if (WRITE_EN === 1'b1) begin
      strobes++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_strobe: observed %0h expected none", INSTRUCTION);
      end
      if (exp_q.size() != 0) begin
        logic [WORD_W-1:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert (INSTRUCTION === e) else begin
          miscompares++;
          $error("FAIL issue_data: observed %0h expected %0h", INSTRUCTION, e);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge CLK);
    SDATA  = b;
    SVALID = 1'b1;
  endtask

  task automatic idle();
    @(negedge CLK);
    SVALID = 1'b0;
    SDATA  = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = 0; i < WORD_W; i++) drive_bit(w[i]);
    idle();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && EMPTY === 1'b1) break;
      @(negedge CLK);
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_empty"}, 32'(EMPTY), 32'd1);
    chk({tag, "_level"}, 32'(LEVEL), 32'd0);
  endtask

  initial begin
    int s0;
    logic [WORD_W-1:0] w;
    RESET_N = 1'b0; SDATA = 1'b0; SVALID = 1'b0; SYNC = 1'b0; STALL = 1'b0; CLR_OVF = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_instr", 32'(INSTRUCTION), 32'd0);
    chk("rst_wen",   32'(WRITE_EN),    32'd0);
    chk("rst_level", 32'(LEVEL),       32'd0);
    chk("rst_empty", 32'(EMPTY),       32'd1);
    chk("rst_full",  32'(FULL),        32'd0);
    chk("rst_ovf",   32'(OVERFLOW),    32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single word: held one cycle in FIFO (no bypass), then one strobe.
    s0 = strobes;
    exp_q.push_back(9'h1A5);
    send_word(9'h1A5);
    chk("single_level_after_push", 32'(LEVEL), 32'd1);
    chk("single_no_bypass", 32'(WRITE_EN), 32'd0);
    @(negedge CLK);
    chk("single_wen", 32'(WRITE_EN), 32'd1);
    chk("single_data", 32'(INSTRUCTION), 32'h1A5);
    @(negedge CLK);
    chk("single_wen_drop", 32'(WRITE_EN), 32'd0);
    chk("single_one_strobe", 32'(strobes - s0), 32'd1);
    wait_drain("single");

    // Back-pressure fill.
    STALL = 1'b1;
    s0 = strobes;
    foreach (exp_q[i]) ;
    exp_q.push_back(9'h001); send_word(9'h001);
    exp_q.push_back(9'h0FF); send_word(9'h0FF);
    exp_q.push_back(9'h100); send_word(9'h100);
    exp_q.push_back(9'h155); send_word(9'h155);
    chk("fill_full",  32'(FULL),  32'd1);
    chk("fill_level", 32'(LEVEL), 32'd4);
    chk("fill_no_strobe", 32'(strobes - s0), 32'd0);
    chk("fill_ovf_clear", 32'(OVERFLOW), 32'd0);

    // Overflow: 0AA dropped and never issued.
    send_word(9'h0AA);
    chk("ovf_set",   32'(OVERFLOW), 32'd1);
    chk("ovf_level", 32'(LEVEL),    32'd4);
    @(negedge CLK); CLR_OVF = 1'b1;
    @(negedge CLK); CLR_OVF = 1'b0;
    chk("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // Full with push and pop on the same edge.
    w = 9'h033;
    for (int i = 0; i < WORD_W - 1; i++) drive_bit(w[i]);
    @(negedge CLK);
    SDATA = w[WORD_W-1]; SVALID = 1'b1; STALL = 1'b0;
    exp_q.push_back(9'h033);
    idle();
    chk("simul_level", 32'(LEVEL), 32'd4);
    chk("simul_full",  32'(FULL),  32'd1);
    chk("simul_ovf",   32'(OVERFLOW), 32'd0);
    chk("simul_wen",   32'(WRITE_EN), 32'd1);
    chk("simul_head",  32'(INSTRUCTION), 32'h001);
    wait_drain("simul");
    chk("simul_strobes", 32'(strobes - s0), 32'd5);
    chk("simul_ovf_end", 32'(OVERFLOW), 32'd0);

    // Resync: 5 garbage bits plus a coincident bit are discarded.
    s0 = strobes;
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge CLK);
    SDATA = 1'b1; SVALID = 1'b1; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0; SVALID = 1'b0;
    exp_q.push_back(9'h12C);
    send_word(9'h12C);
    wait_drain("resync");
    chk("resync_strobes", 32'(strobes - s0), 32'd1);

    // Asynchronous reset with two words queued and a partial word assembled.
    STALL = 1'b1;
    send_word(9'h0F0);
    send_word(9'h00F);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    chk("pre_rst_level", 32'(LEVEL), 32'd2);
    @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    chk("async_rst_instr", 32'(INSTRUCTION), 32'd0);
    chk("async_rst_wen",   32'(WRITE_EN),    32'd0);
    chk("async_rst_level", 32'(LEVEL),       32'd0);
    chk("async_rst_empty", 32'(EMPTY),       32'd1);
    chk("async_rst_full",  32'(FULL),        32'd0);
    @(negedge CLK);
    SVALID = 1'b0; STALL = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    s0 = strobes;
    exp_q.push_back(9'h1FF);
    send_word(9'h1FF);
    wait_drain("post_rst");
    chk("post_rst_strobes", 32'(strobes - s0), 32'd1);
    chk("post_rst_ovf", 32'(OVERFLOW), 32'd0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
